// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Handshake outputs come from registered state only, so decode's ready never reaches fetch combinationally.
module if_id_skid_reg #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int SIDE_W = 1,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic [SIDE_W-1:0] if_side,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [SIDE_W-1:0] id_side,
  output logic [1:0]        occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic [SIDE_W-1:0] skid_side;
  logic              in_fire;
  logic              out_fire;

  assign if_ready  = (state != FULL);
  assign id_valid  = (state != EMPTY);
  assign occupancy = state;
  assign in_fire   = if_valid & if_ready;
  assign out_fire  = id_valid & id_ready;

  // Main register feeds id_* directly; skid catches the entry accepted while decode stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      id_pc     <= RST_PC;
      id_inst   <= '0;
      id_side   <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
      skid_side <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      id_pc   <= RST_PC;
      id_inst <= '0;
      id_side <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state   <= ONE;
            id_pc   <= if_pc;
            id_inst <= if_inst;
            id_side <= if_side;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state     <= FULL;
            skid_pc   <= if_pc;
            skid_inst <= if_inst;
            skid_side <= if_side;
          end else if (!in_fire && out_fire) begin
            state <= EMPTY;
          end else if (in_fire && out_fire) begin
            id_pc   <= if_pc;
            id_inst <= if_inst;
            id_side <= if_side;
          end
        end
        FULL: begin
          if (out_fire) begin
            state   <= ONE;
            id_pc   <= skid_pc;
            id_inst <= skid_inst;
            id_side <= skid_side;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
